// File: rtl/md_if.sv
// EX-stage to multiply/divide controller connection: issue, flush, stall and
// the HI/LO result pair.
interface md_if #(
    parameter int DATA_W = 32
) ();
    logic              start_i;
    logic [2:0]        op_i;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic              flush_i;
    logic              stall_o;
    logic              done_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, flush_i,
        input  stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, flush_i,
        output stall_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/md_ctrl.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide,
// sign fix-up on magnitudes, and ownership of the HI/LO register pair.
module md_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic clk,
    input  logic rst_n,
    md_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]   opnd_q, opnd_d;
    logic                is_div_q, is_div_d;
    logic                signed_q, signed_d;
    logic                sign_a_q, sign_a_d;
    logic                sign_b_q, sign_b_d;
    logic                div0_q, div0_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;

    // Issue-side operand conditioning: magnitudes for signed ops, raw bits otherwise.
    logic                signed_op_s;
    logic                neg_a_s;
    logic                neg_b_s;
    logic [DATA_W-1:0]   abs_a_s;
    logic [DATA_W-1:0]   abs_b_s;

    assign signed_op_s = ~bus.op_i[0];
    assign neg_a_s     = signed_op_s & bus.a_i[DATA_W-1];
    assign neg_b_s     = signed_op_s & bus.b_i[DATA_W-1];
    assign abs_a_s     = neg_a_s ? (~bus.a_i + {{(DATA_W-1){1'b0}}, 1'b1}) : bus.a_i;
    assign abs_b_s     = neg_b_s ? (~bus.b_i + {{(DATA_W-1){1'b0}}, 1'b1}) : bus.b_i;

    // Multiply step: add multiplicand into the upper half when the low bit is set, then shift right.
    logic [DATA_W:0]     mul_sum_s;
    logic [2*DATA_W-1:0] mul_next_s;

    assign mul_sum_s  = {1'b0, prod_q[2*DATA_W-1:DATA_W]}
                      + (prod_q[0] ? {1'b0, opnd_q} : {(DATA_W+1){1'b0}});
    assign mul_next_s = {mul_sum_s, prod_q[DATA_W-1:1]};

    // Divide step: prod holds {remainder, dividend/quotient}; quotient bits enter at the bottom.
    logic [DATA_W:0]     rem_sh_s;
    logic [DATA_W:0]     diff_s;
    logic                fits_s;
    logic [2*DATA_W-1:0] div_next_s;

    assign rem_sh_s   = {prod_q[2*DATA_W-1:DATA_W], prod_q[DATA_W-1]};
    assign diff_s     = rem_sh_s - {1'b0, opnd_q};
    assign fits_s     = ~diff_s[DATA_W];
    assign div_next_s = {(fits_s ? diff_s[DATA_W-1:0] : rem_sh_s[DATA_W-1:0]),
                         prod_q[DATA_W-2:0], fits_s};

    function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v);
        return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    // Next-state and datapath update for the whole controller.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        signed_d = signed_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.flush_i || !bus.start_i) begin
                    state_d = S_IDLE;
                end else begin
                    case (bus.op_i)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            is_div_d = bus.op_i[1];
                            signed_d = signed_op_s;
                            sign_a_d = neg_a_s;
                            sign_b_d = neg_b_s;
                            div0_d   = bus.op_i[1] & (bus.b_i == {DATA_W{1'b0}});
                            cnt_d    = {CNT_W{1'b0}};
                            state_d  = S_RUN;
                            if (bus.op_i[1]) begin
                                prod_d = {{DATA_W{1'b0}}, abs_a_s};
                                opnd_d = abs_b_s;
                            end else begin
                                prod_d = {{DATA_W{1'b0}}, abs_b_s};
                                opnd_d = abs_a_s;
                            end
                        end
                        3'b100:  hi_d = bus.a_i;
                        3'b101:  lo_d = bus.a_i;
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = is_div_q ? div_next_s : mul_next_s;
                    cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_FIX: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                    if (is_div_q) begin
                        // A zero divisor leaves the dividend as remainder; the quotient is forced to all ones.
                        if (div0_q) begin
                            prod_d[DATA_W-1:0] = {DATA_W{1'b1}};
                        end else if (signed_q && (sign_a_q ^ sign_b_q)) begin
                            prod_d[DATA_W-1:0] = neg_w(prod_q[DATA_W-1:0]);
                        end else begin
                            prod_d[DATA_W-1:0] = prod_q[DATA_W-1:0];
                        end
                        if (signed_q && sign_a_q) begin
                            prod_d[2*DATA_W-1:DATA_W] = neg_w(prod_q[2*DATA_W-1:DATA_W]);
                        end else begin
                            prod_d[2*DATA_W-1:DATA_W] = prod_q[2*DATA_W-1:DATA_W];
                        end
                    end else if (signed_q && (sign_a_q ^ sign_b_q)) begin
                        prod_d = ~prod_q + {{(2*DATA_W-1){1'b0}}, 1'b1};
                    end else begin
                        prod_d = prod_q;
                    end
                end
            end
            S_WB: begin
                state_d = S_IDLE;
                if (bus.flush_i) begin
                    done_d = 1'b0;
                end else begin
                    hi_d   = prod_q[2*DATA_W-1:DATA_W];
                    lo_d   = prod_q[DATA_W-1:0];
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            prod_q   <= {(2*DATA_W){1'b0}};
            opnd_q   <= {DATA_W{1'b0}};
            is_div_q <= 1'b0;
            signed_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= {DATA_W{1'b0}};
            lo_q     <= {DATA_W{1'b0}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            signed_q <= signed_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    // The hazard unit needs the stall in the issue cycle itself, so it is not registered.
    assign bus.stall_o = (state_q != S_IDLE) | (bus.start_i & ~bus.op_i[2]);
    assign bus.done_o  = done_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;

endmodule
